// File: rtl/ld_str_exec_unit.sv
// Load/store execution unit: one memory op in flight, result broadcast on the CDB.
// Define LDST_BYTE_OPS_EN to give LDB/STB true byte-lane semantics.
module ld_str_exec_unit #(
    parameter int unsigned data_width = 16,
    parameter int unsigned tag_width  = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  valid_in,
    input  logic [3:0]            opcode_in,
    input  logic [tag_width-1:0]  dest_in,
    input  logic [data_width-1:0] vbase_in,
    input  logic                  vbase_valid_in,
    input  logic [data_width-1:0] vsrc_in,
    input  logic                  vsrc_valid_in,
    input  logic [data_width-1:0] offset_in,
    output logic                  accept_out,
    output logic [data_width-1:0] mem_addr,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [data_width-1:0] mem_wdata,
    output logic [1:0]            mem_byte_enable,
    input  logic [data_width-1:0] mem_rdata,
    input  logic                  mem_resp,
    output logic                  cdb_valid,
    output logic [tag_width-1:0]  cdb_tag,
    output logic [data_width-1:0] cdb_data,
    input  logic                  cdb_grant,
    output logic                  busy
);

    localparam logic [3:0] OpLdb = 4'b0010;
    localparam logic [3:0] OpLdr = 4'b0110;
    localparam logic [3:0] OpStb = 4'b0011;
    localparam logic [3:0] OpStr = 4'b0111;

`ifdef LDST_BYTE_OPS_EN
    localparam bit ByteOpsEn = 1'b1;
`else
    localparam bit ByteOpsEn = 1'b0;
`endif

    typedef enum logic [1:0] {StIdle, StMem, StDrain, StBcast} state_e;

    state_e                state_q, state_d;
    logic                  is_store_q, is_store_d;
    logic                  is_byte_q, is_byte_d;
    logic [tag_width-1:0]  dest_q, dest_d;
    logic [data_width-1:0] vsrc_q, vsrc_d;
    logic [data_width-1:0] addr_q, addr_d;
    logic [data_width-1:0] data_q, data_d;

    logic                  is_load_op, is_store_op, entry_ready;
    logic [7:0]            rd_byte;
    logic [data_width-1:0] load_data, store_wdata;

    assign is_load_op  = (opcode_in == OpLdr) || (opcode_in == OpLdb);
    assign is_store_op = (opcode_in == OpStr) || (opcode_in == OpStb);
    assign entry_ready = valid_in && vbase_valid_in &&
                         (is_load_op || (is_store_op && vsrc_valid_in));

    assign rd_byte   = addr_q[0] ? mem_rdata[15:8] : mem_rdata[7:0];
    assign load_data = is_byte_q ? {{(data_width-8){rd_byte[7]}}, rd_byte} : mem_rdata;
    assign store_wdata = is_byte_q ? data_width'({vsrc_q[7:0], vsrc_q[7:0]}) : vsrc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            is_store_q <= 1'b0;
            is_byte_q  <= 1'b0;
            dest_q     <= '0;
            vsrc_q     <= '0;
            addr_q     <= '0;
            data_q     <= '0;
        end else begin
            state_q    <= state_d;
            is_store_q <= is_store_d;
            is_byte_q  <= is_byte_d;
            dest_q     <= dest_d;
            vsrc_q     <= vsrc_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        is_store_d = is_store_q;
        is_byte_d  = is_byte_q;
        dest_d     = dest_q;
        vsrc_d     = vsrc_q;
        addr_d     = addr_q;
        data_d     = data_q;
        accept_out = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (entry_ready && !flush) begin
                    accept_out = 1'b1;
                    is_store_d = is_store_op;
                    is_byte_d  = ByteOpsEn && ((opcode_in == OpLdb) || (opcode_in == OpStb));
                    dest_d     = dest_in;
                    vsrc_d     = vsrc_in;
                    addr_d     = vbase_in + offset_in;
                    state_d    = StMem;
                end
            end
            StMem: begin
                if (flush) begin
                    // A squashed request still owns the bus until memory answers.
                    state_d = mem_resp ? StIdle : StDrain;
                end else if (mem_resp) begin
                    data_d  = is_store_q ? vsrc_q : load_data;
                    state_d = StBcast;
                end
            end
            StDrain: begin
                if (mem_resp) state_d = StIdle;
            end
            StBcast: begin
                if (flush || cdb_grant) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        mem_addr        = '0;
        mem_read        = 1'b0;
        mem_write       = 1'b0;
        mem_wdata       = '0;
        mem_byte_enable = 2'b00;
        cdb_valid       = 1'b0;
        cdb_tag         = '0;
        cdb_data        = '0;
        busy            = (state_q != StIdle);

        if (state_q == StMem || state_q == StDrain) begin
            mem_addr  = {addr_q[data_width-1:1], 1'b0};
            mem_read  = !is_store_q;
            mem_write = is_store_q;
            mem_wdata = is_store_q ? store_wdata : '0;
            if (is_byte_q) mem_byte_enable = addr_q[0] ? 2'b10 : 2'b01;
            else           mem_byte_enable = 2'b11;
        end

        if (state_q == StBcast) begin
            cdb_valid = 1'b1;
            cdb_tag   = dest_q;
            cdb_data  = data_q;
        end
    end

endmodule

// File: tb/tb_ld_str_exec_unit.sv
// Self-checking bench for ld_str_exec_unit: directed vector table, corner sequences and
// random transactions against a transaction-level model.
module tb_ld_str_exec_unit;

`ifdef LDST_BYTE_OPS_EN
    localparam bit ByteEn = 1'b1;
`else
    localparam bit ByteEn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        valid_in = 1'b0;
    logic [3:0]  opcode_in = '0;
    logic [2:0]  dest_in = '0;
    logic [15:0] vbase_in = '0;
    logic        vbase_valid_in = 1'b0;
    logic [15:0] vsrc_in = '0;
    logic        vsrc_valid_in = 1'b0;
    logic [15:0] offset_in = '0;
    logic        accept_out;
    logic [15:0] mem_addr;
    logic        mem_read, mem_write;
    logic [15:0] mem_wdata;
    logic [1:0]  mem_byte_enable;
    logic [15:0] mem_rdata = '0;
    logic        mem_resp = 1'b0;
    logic        cdb_valid;
    logic [2:0]  cdb_tag;
    logic [15:0] cdb_data;
    logic        cdb_grant = 1'b0;
    logic        busy;

    int checks = 0;
    int errors = 0;

    ld_str_exec_unit dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .valid_in(valid_in),
        .opcode_in(opcode_in), .dest_in(dest_in), .vbase_in(vbase_in),
        .vbase_valid_in(vbase_valid_in), .vsrc_in(vsrc_in), .vsrc_valid_in(vsrc_valid_in),
        .offset_in(offset_in), .accept_out(accept_out), .mem_addr(mem_addr),
        .mem_read(mem_read), .mem_write(mem_write), .mem_wdata(mem_wdata),
        .mem_byte_enable(mem_byte_enable), .mem_rdata(mem_rdata), .mem_resp(mem_resp),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .cdb_grant(cdb_grant), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic [3:0]  op;
        logic [15:0] vbase, off, vsrc;
        logic [2:0]  dest;
        logic [15:0] rdata;
        int          rk, gd;
        logic [15:0] e_addr;
        logic        e_rd, e_wr;
        logic [15:0] e_wdata;
        logic [1:0]  e_be;
        logic [15:0] e_cdb;
    } txn_t;

    txn_t vec[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [3:0] op, input logic [15:0] vb, input logic [15:0] off,
                           input logic [15:0] vs, input logic [2:0] dst);
        valid_in = 1'b1; opcode_in = op; vbase_in = vb; offset_in = off;
        vsrc_in = vs; dest_in = dst; vbase_valid_in = 1'b1; vsrc_valid_in = 1'b1;
    endtask

    task automatic withdraw();
        valid_in = 1'b0; vbase_valid_in = 1'b0; vsrc_valid_in = 1'b0;
    endtask

    // Full transaction: accept, rk request cycles (resp on the last), gd ungranted cycles.
    task automatic run_txn(input txn_t t);
        present(t.op, t.vbase, t.off, t.vsrc, t.dest);
        @(negedge clk);
        chk("accept", accept_out, 1);
        step();
        withdraw();
        mem_rdata = t.rdata;
        for (int i = 0; i < t.rk; i++) begin
            mem_resp = (i == t.rk - 1);
            @(negedge clk);
            chk("mem_read", mem_read, t.e_rd);
            chk("mem_write", mem_write, t.e_wr);
            chk("mem_addr", mem_addr, t.e_addr);
            chk("mem_wdata", mem_wdata, t.e_wdata);
            chk("mem_be", mem_byte_enable, t.e_be);
            chk("cdb_valid_mem", cdb_valid, 0);
            step();
        end
        mem_resp = 1'b0;
        for (int j = 0; j <= t.gd; j++) begin
            cdb_grant = (j == t.gd);
            @(negedge clk);
            chk("cdb_valid", cdb_valid, 1);
            chk("cdb_tag", cdb_tag, t.dest);
            chk("cdb_data", cdb_data, t.e_cdb);
            chk("req_low_bcast", {mem_read, mem_write}, 0);
            step();
        end
        cdb_grant = 1'b0;
        @(negedge clk);
        chk("busy_end", busy, 0);
        chk("cdb_valid_end", cdb_valid, 0);
        step();
    endtask

    // Reference model: expected bus/result values from the architectural rules.
    task automatic model(inout txn_t t);
        logic [15:0] a;
        bit st, by;
        int b;
        a  = t.vbase + t.off;
        st = (t.op == 4'd3) || (t.op == 4'd7);
        by = ByteEn && ((t.op == 4'd2) || (t.op == 4'd3));
        t.e_addr = a & 16'hFFFE;
        t.e_rd   = !st;
        t.e_wr   = st;
        t.e_be   = by ? ((a % 2 == 1) ? 2'd2 : 2'd1) : 2'd3;
        if (!st) t.e_wdata = 0;
        else if (by) t.e_wdata = 16'((t.vsrc & 16'hFF) * 257);
        else t.e_wdata = t.vsrc;
        if (st) t.e_cdb = t.vsrc;
        else if (by) begin
            b = (int'(t.rdata) >> (8 * (a % 2))) & 255;
            t.e_cdb = 16'((b >= 128) ? b + 16'hFF00 : b);
        end else t.e_cdb = t.rdata;
    endtask

    initial begin
        txn_t t;
        logic [3:0] ops[4];
        ops[0] = 4'd2; ops[1] = 4'd3; ops[2] = 4'd6; ops[3] = 4'd7;

        vec[0] = '{4'd6, 16'h3000, 16'h0004, 16'h0000, 3'd5, 16'hBEEF, 3, 0,
                   16'h3004, 1'b1, 1'b0, 16'h0000, 2'b11, 16'hBEEF};
        vec[1] = '{4'd6, 16'hFFFE, 16'h0004, 16'h0000, 3'd3, 16'h0042, 2, 0,
                   16'h0002, 1'b1, 1'b0, 16'h0000, 2'b11, 16'h0042};
        vec[2] = '{4'd7, 16'h2000, 16'hFFFE, 16'hABCD, 3'd4, 16'h0000, 1, 2,
                   16'h1FFE, 1'b0, 1'b1, 16'hABCD, 2'b11, 16'hABCD};
        vec[3] = '{4'd6, 16'h5000, 16'h0001, 16'h0000, 3'd7, 16'h1357, 1, 1,
                   16'h5000, 1'b1, 1'b0, 16'h0000, 2'b11, 16'h1357};
`ifdef LDST_BYTE_OPS_EN
        vec[4] = '{4'd2, 16'h4001, 16'h0000, 16'h0000, 3'd1, 16'h80FF, 1, 1,
                   16'h4000, 1'b1, 1'b0, 16'h0000, 2'b10, 16'hFF80};
        vec[5] = '{4'd3, 16'h1000, 16'h0003, 16'h12C3, 3'd2, 16'h0000, 2, 0,
                   16'h1002, 1'b0, 1'b1, 16'hC3C3, 2'b10, 16'h12C3};
        vec[6] = '{4'd2, 16'h4000, 16'h0000, 16'h0000, 3'd6, 16'h127F, 1, 0,
                   16'h4000, 1'b1, 1'b0, 16'h0000, 2'b01, 16'h007F};
`else
        vec[4] = '{4'd2, 16'h4001, 16'h0000, 16'h0000, 3'd1, 16'h80FF, 1, 1,
                   16'h4000, 1'b1, 1'b0, 16'h0000, 2'b11, 16'h80FF};
        vec[5] = '{4'd3, 16'h1000, 16'h0003, 16'h12C3, 3'd2, 16'h0000, 2, 0,
                   16'h1002, 1'b0, 1'b1, 16'h12C3, 2'b11, 16'h12C3};
        vec[6] = '{4'd2, 16'h4000, 16'h0000, 16'h0000, 3'd6, 16'h127F, 1, 0,
                   16'h4000, 1'b1, 1'b0, 16'h0000, 2'b11, 16'h127F};
`endif

        // Reset state
        #2;
        chk("rst_busy", busy, 0);
        chk("rst_req", {mem_read, mem_write}, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_cdb", {cdb_valid, cdb_tag, cdb_data}, 0);
        chk("rst_accept", accept_out, 0);
        step();
        rst_n = 1'b1;
        step();

        foreach (vec[i]) run_txn(vec[i]);

        // Store waits for its source operand
        present(4'd7, 16'h0600, 16'h0000, 16'h0000, 3'd1);
        vsrc_valid_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("str_wait_accept", accept_out, 0);
            step();
        end
        vsrc_valid_in = 1'b1; vsrc_in = 16'h1234;
        @(negedge clk);
        chk("str_late_accept", accept_out, 1);
        step();
        withdraw();
        mem_resp = 1'b1;
        @(negedge clk);
        chk("str_write", {mem_write, mem_read}, 2'b10);
        chk("str_wdata", mem_wdata, 16'h1234);
        chk("str_be", mem_byte_enable, 2'b11);
        step();
        mem_resp = 1'b0; cdb_grant = 1'b1;
        @(negedge clk);
        chk("str_cdb", {cdb_valid, cdb_data}, {1'b1, 16'h1234});
        step();
        cdb_grant = 1'b0;

        // Flush in MEM drains without broadcast
        present(4'd6, 16'h0100, 16'h0002, 16'h0000, 3'd3);
        step();
        withdraw();
        flush = 1'b1;
        @(negedge clk);
        chk("flush_mem_read", mem_read, 1);
        step();
        flush = 1'b0;
        @(negedge clk);
        chk("drain_read", mem_read, 1);
        chk("drain_addr", mem_addr, 16'h0102);
        chk("drain_busy", busy, 1);
        step();
        mem_resp = 1'b1;
        @(negedge clk);
        chk("drain_read2", mem_read, 1);
        chk("drain_cdb", cdb_valid, 0);
        step();
        mem_resp = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("drain_done", {busy, cdb_valid, mem_read}, 0);
            step();
        end

        // Flush coinciding with mem_resp goes straight to idle
        present(4'd6, 16'h0200, 16'h0000, 16'h0000, 3'd2);
        step();
        withdraw();
        flush = 1'b1; mem_resp = 1'b1;
        step();
        flush = 1'b0; mem_resp = 1'b0;
        @(negedge clk);
        chk("flush_resp_idle", {busy, cdb_valid, mem_read}, 0);
        step();

        // Grant withheld while another entry waits
        present(4'd6, 16'h0300, 16'h0000, 16'h0000, 3'd6);
        step();
        present(4'd6, 16'h0400, 16'h0000, 16'h0000, 3'd2);
        mem_rdata = 16'h5A5A; mem_resp = 1'b1;
        @(negedge clk);
        chk("hold_mem_accept", accept_out, 0);
        step();
        mem_resp = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("hold_cdb", {cdb_valid, cdb_tag, cdb_data}, {1'b1, 3'd6, 16'h5A5A});
            chk("hold_accept", accept_out, 0);
            step();
        end
        cdb_grant = 1'b1;
        @(negedge clk);
        chk("grant_cycle_accept", accept_out, 0);
        step();
        cdb_grant = 1'b0;
        @(negedge clk);
        chk("post_grant_accept", accept_out, 1);
        step();
        withdraw();
        mem_rdata = 16'h0F0F; mem_resp = 1'b1;
        step();
        mem_resp = 1'b0; cdb_grant = 1'b1;
        @(negedge clk);
        chk("second_cdb", {cdb_valid, cdb_tag, cdb_data}, {1'b1, 3'd2, 16'h0F0F});
        step();
        cdb_grant = 1'b0;

        // Flush in BCAST
        present(4'd6, 16'h0500, 16'h0000, 16'h0000, 3'd4);
        step();
        withdraw();
        mem_resp = 1'b1;
        step();
        mem_resp = 1'b0; flush = 1'b1;
        @(negedge clk);
        chk("bcast_before_flush", cdb_valid, 1);
        step();
        flush = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("bcast_flushed", {cdb_valid, busy}, 0);
            step();
        end

        // Flush in IDLE and non-memory opcodes block acceptance
        present(4'd6, 16'h0700, 16'h0000, 16'h0000, 3'd1);
        flush = 1'b1;
        @(negedge clk);
        chk("flush_idle_accept", accept_out, 0);
        step();
        flush = 1'b0;
        @(negedge clk);
        chk("flush_idle_busy", busy, 0);
        withdraw();
        step();
        for (int i = 0; i < 3; i++) begin
            logic [3:0] bad[3];
            bad[0] = 4'd1; bad[1] = 4'd14; bad[2] = 4'd12;
            present(bad[i], 16'h0800, 16'h0000, 16'h0000, 3'd1);
            @(negedge clk);
            chk("bad_op_accept", accept_out, 0);
            step();
            chk("bad_op_busy", busy, 0);
        end
        withdraw();

        // Reset mid-MEM abandons the request
        present(4'd6, 16'h0900, 16'h0000, 16'h0000, 3'd5);
        step();
        withdraw();
        @(negedge clk);
        chk("pre_rst_read", mem_read, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_mid_read", mem_read, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_addr", mem_addr, 0);
        step();
        rst_n = 1'b1;
        mem_resp = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_rst_cdb", {cdb_valid, busy}, 0);
            step();
            mem_resp = 1'b0;
        end

        // Random transactions against the model
        for (int n = 0; n < 40; n++) begin
            t.op    = ops[$urandom_range(0, 3)];
            t.vbase = 16'($urandom);
            t.off   = 16'($urandom);
            t.vsrc  = 16'($urandom);
            t.dest  = 3'($urandom);
            t.rdata = 16'($urandom);
            t.rk    = int'($urandom_range(1, 4));
            t.gd    = int'($urandom_range(0, 3));
            model(t);
            run_txn(t);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ld_str_exec_unit.md
LD_STR_EXEC_UNIT -- requirements
Module: ld_str_exec_unit

Interface
REQ-001 SHALL have parameter data_width, default 16, operand/address/data width.
REQ-002 SHALL have parameter tag_width, default 3, ROB tag width.
REQ-003 SHALL have ports clk input 1, the rising-edge clock, and rst_n input 1, the asynchronous active-low reset.
REQ-004 SHALL have port flush input 1, the synchronous pipeline squash.
REQ-005 SHALL have port valid_in input 1, meaning the reservation-station entry is occupied.
REQ-006 SHALL have ports opcode_in input 4 (lc3b_opcode) and dest_in input tag_width, the ROB tag.
REQ-007 SHALL have ports vbase_in input data_width, vbase_valid_in input 1, vsrc_in input data_width, vsrc_valid_in input 1, and offset_in input data_width (pre-scaled, sign-extended).
REQ-008 SHALL have port accept_out output 1, a one-cycle pulse meaning the entry was consumed and the station may clear.
REQ-009 SHALL have ports mem_addr output data_width, mem_read output 1, mem_write output 1, mem_wdata output data_width, mem_byte_enable output 2, mem_rdata input data_width, and mem_resp input 1.
REQ-010 SHALL have ports cdb_valid output 1, cdb_tag output tag_width, cdb_data output data_width, and cdb_grant input 1.
REQ-011 SHALL have port busy output 1, high whenever state is not IDLE.

Function
REQ-012 SHALL implement states IDLE, MEM, DRAIN, BCAST; at most one operation in flight.
REQ-013 In IDLE, an entry is ready when valid_in=1, vbase_valid_in=1, and opcode is a load (LDR/LDB), or is a store (STR/STB) with vsrc_valid_in=1; any other opcode is never accepted.
REQ-014 In IDLE with a ready entry and flush=0, the block SHALL pulse accept_out combinationally that cycle, latch opcode, dest, vsrc, and addr=vbase_in+offset_in (mod 2^data_width, carry dropped), then enter MEM.
REQ-015 In MEM, the block SHALL drive mem_read (load) or mem_write (store) from registered state, hold mem_addr/mem_wdata/mem_byte_enable stable, and remain in MEM until mem_resp=1.
REQ-016 Word ops SHALL drive mem_addr with bit0 cleared, mem_byte_enable=2'b11, and mem_wdata=vsrc.
REQ-017 On mem_resp in MEM, the block SHALL capture load data (store data = latched vsrc) into cdb_data and enter BCAST; mem_read/mem_write SHALL be low the following cycle.
REQ-018 In BCAST, the block SHALL hold cdb_valid=1 with stable cdb_tag=dest and cdb_data until cdb_grant=1, then return to IDLE; a new entry SHALL NOT be accepted in the grant cycle.
REQ-019 Latency: accept at edge 0, request visible cycle 1, mem_resp at cycle k, cdb_valid at cycle k+1.
REQ-020 Flush in IDLE SHALL block acceptance; flush in BCAST SHALL go to IDLE with no further cdb_valid.
REQ-021 Flush in MEM SHALL go to DRAIN, or to IDLE if mem_resp arrives in the same cycle; DRAIN SHALL keep the request asserted until mem_resp, then go to IDLE without broadcasting.
REQ-022 When idle, outputs not otherwise driven SHALL be 0.

Reset
REQ-023 rst_n=0 SHALL asynchronously force IDLE, with accept_out, mem_read, mem_write, cdb_valid, and busy all 0, and mem_addr, mem_wdata, mem_byte_enable, cdb_tag, and cdb_data all 0.
REQ-024 Reset mid-MEM SHALL abandon the request immediately, with no drain.

Configuration
REQ-025 With LDST_BYTE_OPS_EN defined, LDB SHALL select mem_rdata[15:8] if addr[0] else mem_rdata[7:0] and sign-extend it; STB SHALL drive mem_wdata={vsrc[7:0],vsrc[7:0]} and mem_byte_enable=2'b10 if addr[0] else 2'b01.
REQ-026 Without LDST_BYTE_OPS_EN, LDB/STB SHALL execute exactly as LDR/STR.

Verification
REQ-027 LDR with vbase=0x3000, offset=0x0004, dest=5, mem_resp after 3 cycles with rdata=0xBEEF -> mem_addr=0x3004, mem_read=1 for 3 cycles, then cdb_valid, tag=5, data=0xBEEF.
REQ-028 STR with vsrc_valid_in=0 for 4 cycles, then 1 (vsrc=0x1234) -> no accept_out until the 5th cycle, then mem_write=1, wdata=0x1234, be=2'b11.
REQ-029 LDB with vbase=0x4001, offset=0, rdata=0x80FF, macro on -> cdb_data=0xFF80; macro off -> cdb_data=0x80FF with mem_addr=0x4000.
REQ-030 Flush 1 cycle after accept of a load, mem_resp 2 cycles later -> mem_read held until mem_resp, no cdb_valid, then busy=0.
REQ-031 cdb_grant withheld 3 cycles with valid_in held -> cdb_valid, tag, and data stable all 3 cycles; next accept_out no earlier than 1 cycle after grant.
REQ-032 vbase=0xFFFE, offset=0x0004 -> mem_addr=0x0002; rst_n=0 mid-MEM -> mem_read=0 immediately, no cdb_valid after reset release.
